// File: rtl/uart_tx_drain_if.sv
// FIFO-read / UART-TX bundle for the sample drain.
//
// Handshake (read side): the master issues o_rden as a one-cycle pulse only
// when i_empty is low, and i_fifo_data holds the popped word the cycle after
// that pulse. There is no back-pressure: the master issues at most one read
// per frame. state_dbg exposes the drain FSM encoding for observation.
interface uart_tx_drain_if #(
  parameter int WIDTH = 8
);
  logic             i_en;
  logic             i_empty;
  logic [WIDTH-1:0] i_fifo_data;
  logic             o_rden;
  logic             o_tx;
  logic             o_busy;
  logic             o_done;
  logic [2:0]       state_dbg;

  // Drain side: reads the FIFO and drives the TX pin.
  modport master (
    input  i_en,
    input  i_empty,
    input  i_fifo_data,
    output o_rden,
    output o_tx,
    output o_busy,
    output o_done,
    output state_dbg
  );

  // Environment side: FIFO read port plus enable, observes the line.
  modport slave (
    output i_en,
    output i_empty,
    output i_fifo_data,
    input  o_rden,
    input  o_tx,
    input  o_busy,
    input  o_done,
    input  state_dbg
  );
endinterface

// File: rtl/uart_tx_drain.sv
// Pops bytes from the sample FIFO and serializes each one on a UART TX line
// (start, WIDTH data bits LSB first, optional parity, one stop bit).
// The TX line and the read strobe come straight from flops.
module uart_tx_drain #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 104,
  parameter int PARITY       = 0
) (
  input  logic           i_clk,
  input  logic           i_rst,
  uart_tx_drain_if.master bus
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
  // Values other than 1 (odd) or 2 (even) mean no parity bit.
  localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
  localparam bit PAR_ODD = (PARITY == 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    PAR   = 3'd5,
    STOP  = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             rden_q, rden_d;
  logic             bit_end;

  // Last cycle of the current bit period.
  assign bit_end = (cnt_q == CNT_LAST);

  // State and datapath registers; reset puts the line idle-high at once.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sr_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rden_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      rden_q  <= rden_d;
    end
  end

  // Next-state logic; tx_d is the value the line takes in the next cycle,
  // so bit values are loaded one cycle ahead of each bit boundary.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    idx_d   = idx_q;
    sr_d    = sr_q;
    par_d   = par_q;
    tx_d    = tx_q;
    rden_d  = 1'b0;

    // The baud counter only runs while a bit is on the line and wraps at
    // every bit boundary.
    if (state_q == START || state_q == DATA ||
        state_q == PAR   || state_q == STOP) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        // Emptiness is only trusted here; the flag can lag the pop later on.
        if (bus.i_en && !bus.i_empty) begin
          state_d = FETCH;
          rden_d  = 1'b1;
        end
      end
      FETCH: begin
        state_d = LATCH;
      end
      LATCH: begin
        sr_d    = bus.i_fifo_data;
        par_d   = PAR_ODD ? ~(^bus.i_fifo_data) : ^bus.i_fifo_data;
        tx_d    = 1'b0;
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = sr_q[0];
          sr_d    = sr_q >> 1;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            if (PAR_EN) begin
              state_d = PAR;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
            tx_d  = sr_q[0];
            sr_d  = sr_q >> 1;
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign bus.o_tx      = tx_q;
  assign bus.o_rden    = rden_q;
  assign bus.o_busy    = (state_q != IDLE);
  assign bus.o_done    = (state_q == STOP) && bit_end;
  assign bus.state_dbg = state_q;

endmodule

// File: doc/uart_tx_drain.md
# uart_tx_drain

- Downstream consumer of the sample FIFO in the ADXL345 IMU datapath.
- Pops bytes from the FIFO read port whenever it is non-empty and serializes each byte onto a UART TX line as 8-N-1, with optional parity.
- Sits between the FIFO and the FPGA TX pin, so buffered accelerometer samples stream to the host without stalling the SPI side.

## Interface
- `WIDTH`, default 8: data bits per frame; must match the FIFO `WIDTH`.
- `CLKS_PER_BIT`, default 104: `i_clk` cycles per UART bit (12 MHz / 115200); legal range ≥ 2.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even; any other value is treated as none.
- `i_clk`  input  1  system clock; all logic is on its rising edge.
- `i_rst`  input  1  reset, asynchronous assert, active-low.
- `i_en`  input  1  drain enable; when low, no new byte is fetched.
- `i_empty`  input  1  FIFO `empty` flag.
- `i_fifo_data`  input  WIDTH  FIFO `o_dataout`; valid the cycle after a read strobe.
- `o_rden`  output  1  FIFO read strobe; a registered, one-cycle pulse.
- `o_tx`  output  1  UART TX line; idles high.
- `o_busy`  output  1  high from fetch through the end of the stop bit.
- `o_done`  output  1  one-cycle pulse in the final cycle of the stop bit.

## Operation
- **Reset values:** `o_tx`=1, `o_rden`=0, `o_busy`=0, `o_done`=0, state IDLE, baud counter 0, bit index 0.
- **FSM states:** IDLE, FETCH, LATCH, START, DATA, PAR, STOP.
- **IDLE:** if `i_en` and !`i_empty` → FETCH, registering `o_rden`<=1. Otherwise stay in IDLE with `o_tx`=1.
- **FETCH:** `o_rden` is high for exactly this cycle → LATCH, with `o_rden`<=0.
- **LATCH:** capture `i_fifo_data` into the shift register and compute the parity bit → START, with `o_tx`<=0.
- **START, DATA, PAR, STOP:**
  - Each bit is held for exactly CLKS_PER_BIT cycles, timed by a counter of width $clog2(CLKS_PER_BIT).
  - The counter reloads at every bit boundary.
- **DATA:** sends WIDTH bits LSB first, with a bit index 0..WIDTH-1. After the last bit → PAR if parity is enabled, else STOP.
- **Parity bit:**
  - even: XOR of the data bits.
  - odd: inverted XOR of the data bits.
- **STOP:** `o_tx`=1. `o_done` pulses in the final cycle of the stop bit → IDLE.
- **`o_rden` rules:**
  - Never asserted while `i_empty` is high.
  - Never asserted outside FETCH.
  - At most one read per frame, so the FIFO underflow flag can never be set by this block.
- **`i_en` deasserted mid-frame:** the current frame completes normally. No further fetch occurs until `i_en` is high again.
- **Reset mid-frame:** asynchronous. `o_tx` goes to 1 immediately and the FSM returns to IDLE. The byte already popped is discarded and is not re-read.
- **`i_empty` in LATCH/START:** ignored. It may still be stale from the pop, so emptiness is only sampled in IDLE.

## Timing
- Let cycle T be the IDLE cycle that sees `i_en`=1 and `i_empty`=0:
  - `o_rden`=1 and `o_busy`=1 during T+1 (FETCH).
  - T+2 is LATCH.
  - The start bit begins at T+3.
- Frame length from the start bit to the end of the stop bit: (1 + WIDTH + P + 1) × CLKS_PER_BIT cycles, where P=1 if parity is enabled, else 0.
- `o_busy` falls in the cycle after `o_done`.
- **Back-to-back frames:** with the FIFO non-empty, the line stays high for exactly 3 cycles (IDLE, FETCH, LATCH) between the end of a stop bit and the next start bit.
- Max throughput is therefore one byte per (frame + 3) cycles.
- `o_tx` is driven from a register, so it is glitch-free.

## Test plan
- **Single byte:** CLKS_PER_BIT=4, PARITY=0, FIFO holds 0xA5. Required response:
  - exactly one `o_rden` pulse;
  - `o_tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles;
  - `o_done` in cycle 40 after the start bit begins.
- **Parity:** 0xA5 with PARITY=2 → parity bit 0. The same byte with PARITY=1 → parity bit 1. Frame is 44 cycles.
- **Burst:** FIFO holds 0x00, 0xFF, 0x3C → three frames in order, with exactly 3 high cycles between each stop bit and the next start bit. After the third frame, `i_empty`=1 and `o_rden` stays 0.
- **Enable gating:** drop `i_en` during the DATA state of frame 1 with 2 bytes queued:
  - frame 1 completes;
  - no second `o_rden` occurs;
  - raising `i_en` later starts frame 2 three cycles later.
- **Reset mid-frame:** assert `i_rst` low during bit 3. Required response:
  - `o_tx`=1 before the next clock edge;
  - `o_busy`=0 and `o_rden`=0;
  - after release, the next queued byte is sent and the interrupted byte is not.
- **Empty FIFO:** hold `i_empty`=1 and `i_en`=1 for 1000 cycles → `o_rden`=0 and `o_tx`=1 throughout.
